// File: rtl/keypad_pkg.sv
// keypad_pkg: shared constants and types for keypad key consumers.
//   - Key code constants for the editing keys (digits are codes 0-9).
//   - key_class_e: classification of a scanner key code.
//   - entry_state_e: occupancy state of the BCD entry buffer.
//   - state_for_count(): maps a digit count to its entry state.
package keypad_pkg;

    localparam int BCD_W = 4;

    localparam logic [3:0] KEY_BACKSPACE = 4'd10;
    localparam logic [3:0] KEY_CLEAR     = 4'd11;
    localparam logic [3:0] KEY_ENTER     = 4'd14;

    typedef enum logic [2:0] {
        DIGIT,
        BACKSPACE,
        CLEAR,
        ENTER,
        IGNORED
    } key_class_e;

    typedef enum logic [1:0] {
        EMPTY,
        ENTRY,
        FULL
    } entry_state_e;

    function automatic entry_state_e state_for_count(input logic [3:0] count,
                                                     input logic [3:0] full_count);
        if (count == 4'd0) begin
            return EMPTY;
        end else if (count >= full_count) begin
            return FULL;
        end
        return ENTRY;
    endfunction

endpackage

// File: rtl/keypad_entry_if.sv
// keypad_entry_if: key stream in, entry/commit bus out.
//   key_code, data_ready      : scanner -> entry (strobe qualifies key_code)
//   digits, digit_count       : live BCD entry for the display mux
//   value_bcd, value_valid    : committed entry with one-cycle valid pulse
//   overflow, timeout         : sticky drop flag, auto-clear pulse
// master = key source / result consumer side, slave = keypad_entry.
interface keypad_entry_if #(
    parameter int NUM_DIGITS = 4
);
    logic [3:0]                             key_code;
    logic                                   data_ready;
    logic [keypad_pkg::BCD_W*NUM_DIGITS-1:0] digits;
    logic [3:0]                             digit_count;
    logic [keypad_pkg::BCD_W*NUM_DIGITS-1:0] value_bcd;
    logic                                   value_valid;
    logic                                   overflow;
    logic                                   timeout;

    modport master (
        output key_code, data_ready,
        input  digits, digit_count, value_bcd, value_valid, overflow, timeout
    );

    modport slave (
        input  key_code, data_ready,
        output digits, digit_count, value_bcd, value_valid, overflow, timeout
    );
endinterface

// File: rtl/keypad_key_decoder.sv
// keypad_key_decoder: combinational classification of a 4-bit key code.
//   key_code_i  : raw key code from the scanner
//   key_class_o : DIGIT / BACKSPACE / CLEAR / ENTER / IGNORED
//   digit_o     : digit value for DIGIT keys, 0 otherwise
module keypad_key_decoder
    import keypad_pkg::*;
(
    input  logic [3:0] key_code_i,
    output key_class_e key_class_o,
    output logic [3:0] digit_o
);

    always_comb begin
        key_class_o = IGNORED;
        digit_o     = 4'd0;
        if (key_code_i <= 4'd9) begin
            key_class_o = DIGIT;
            digit_o     = key_code_i;
        end else begin
            case (key_code_i)
                KEY_BACKSPACE: key_class_o = BACKSPACE;
                KEY_CLEAR:     key_class_o = CLEAR;
                KEY_ENTER:     key_class_o = ENTER;
                default:       key_class_o = IGNORED;
            endcase
        end
    end

endmodule

// File: rtl/keypad_entry.sv
// keypad_entry: BCD entry buffer with backspace/clear/enter editing.
//   clock, reset : system clock, synchronous active-high reset
//   bus (slave)  : key_code/data_ready in; digits, digit_count, value_bcd,
//                  value_valid, overflow, timeout out
// Digits shift in at nibble 0 (most recent digit least significant).
// Every accepted key takes effect on the cycle after its strobe.
// Optional macro KEYPAD_ENTRY_TIMEOUT_EN adds an idle auto-clear after
// TIMEOUT_CYCLES cycles without a strobe while the buffer is non-empty.
module keypad_entry
    import keypad_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input  logic          clock,
    input  logic          reset,
    keypad_entry_if.slave bus
);

    localparam int         W          = BCD_W * NUM_DIGITS;
    localparam logic [3:0] FULL_COUNT = 4'(NUM_DIGITS);

    if (NUM_DIGITS < 1 || NUM_DIGITS > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("keypad_entry: NUM_DIGITS must be 1..8 and TIMEOUT_CYCLES >= 1");
    end

    key_class_e   key_class;
    logic [3:0]   key_digit;

    logic [W-1:0] digits_q, digits_d;
    logic [3:0]   count_q, count_d;
    entry_state_e state_q, state_d;
    logic [W-1:0] value_q, value_d;
    logic         valid_q, valid_d;
    logic         ovf_q, ovf_d;
    logic         timeout_q, timeout_d;
    logic         expire;

    keypad_key_decoder u_decoder (
        .key_code_i  (bus.key_code),
        .key_class_o (key_class),
        .digit_o     (key_digit)
    );

`ifdef KEYPAD_ENTRY_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] idle_q, idle_d;

    // Any strobe (even an ignored code) counts as activity and restarts
    // the count; expiry fires on the cycle the count would hit the limit.
    always_comb begin
        idle_d = idle_q;
        expire = 1'b0;
        if (bus.data_ready || state_q == EMPTY) begin
            idle_d = '0;
        end else if (idle_q == TW'(TIMEOUT_CYCLES - 1)) begin
            idle_d = '0;
            expire = 1'b1;
        end else begin
            idle_d = idle_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`else
    assign expire = 1'b0;
`endif

    always_comb begin
        digits_d  = digits_q;
        count_d   = count_q;
        value_d   = value_q;
        ovf_d     = ovf_q;
        valid_d   = 1'b0;
        timeout_d = 1'b0;
        if (bus.data_ready) begin
            case (key_class)
                DIGIT: begin
                    if (state_q != FULL) begin
                        digits_d = (digits_q << BCD_W) | W'(key_digit);
                        count_d  = count_q + 4'd1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
                BACKSPACE: begin
                    if (state_q != EMPTY) begin
                        digits_d = digits_q >> BCD_W;
                        count_d  = count_q - 4'd1;
                        ovf_d    = 1'b0;
                    end
                end
                CLEAR: begin
                    digits_d = '0;
                    count_d  = 4'd0;
                    ovf_d    = 1'b0;
                end
                ENTER: begin
                    if (state_q != EMPTY) begin
                        value_d  = digits_q;
                        valid_d  = 1'b1;
                        digits_d = '0;
                        count_d  = 4'd0;
                        ovf_d    = 1'b0;
                    end
                end
                default: ;
            endcase
        end else if (expire) begin
            digits_d  = '0;
            count_d   = 4'd0;
            ovf_d     = 1'b0;
            timeout_d = 1'b1;
        end
        state_d = state_for_count(count_d, FULL_COUNT);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            digits_q  <= '0;
            count_q   <= 4'd0;
            state_q   <= EMPTY;
            value_q   <= '0;
            valid_q   <= 1'b0;
            ovf_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            digits_q  <= digits_d;
            count_q   <= count_d;
            state_q   <= state_d;
            value_q   <= value_d;
            valid_q   <= valid_d;
            ovf_q     <= ovf_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.digits      = digits_q;
    assign bus.digit_count = count_q;
    assign bus.value_bcd   = value_q;
    assign bus.value_valid = valid_q;
    assign bus.overflow    = ovf_q;
    assign bus.timeout     = timeout_q;

endmodule
